shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand pair m/q is presented.
REQ-005 Port: in_ready  output  1  block can accept an operand pair.
REQ-006 Port: m  input  WIDTH  multiplicand.
REQ-007 Port: q  input  WIDTH  multiplier.
REQ-008 Port: out_valid  output  1  product p is valid.
REQ-009 Port: out_ready  input  1  consumer accepts p.
REQ-010 Port: p  output  2*WIDTH  product.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE and SHALL NOT depend combinationally on any input.
REQ-013 Accept occurs on a rising edge with in_valid=1 and in_ready=1: m and q are latched, the accumulator and bit counter are cleared, and the FSM enters CALC.
REQ-014 In CALC, each cycle SHALL add the multiplicand, shifted left by the counter value, to the accumulator when the current multiplier bit is 1, then increment the counter.
REQ-015 CALC SHALL last exactly WIDTH cycles; for an accept at edge k, out_valid SHALL rise at edge k+WIDTH.
REQ-016 In DONE, out_valid=1 and p SHALL equal the full 2*WIDTH-bit product with no truncation; p SHALL hold stable while out_ready=0.
REQ-017 At an edge in DONE with out_ready=1, the FSM SHALL return to IDLE; the next accept SHALL occur no earlier than the following edge.
REQ-018 in_valid in CALC or DONE SHALL be ignored; m/q changes after accept SHALL NOT affect the result.
REQ-019 p SHALL retain the last product in IDLE and CALC until the next DONE entry; out_valid=0 outside DONE.
REQ-020 Throughput: one product per WIDTH+2 cycles at most with out_ready held at 1.
REQ-021 Zero operands SHALL NOT terminate CALC early; latency is fixed.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, counter=0, accumulator=0, p=0, out_valid=0, in_ready=1 after release.
REQ-023 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no out_valid pulse SHALL follow release.
REQ-024 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro SIGNED_MULT_EN: when defined, m, q and p SHALL be two's complement.
REQ-026 Signed mode: operands SHALL be converted to magnitudes at accept, the unsigned core SHALL run WIDTH cycles, and the result SHALL be negated on entry to DONE when the operand signs differ; latency is unchanged.
REQ-027 Signed mode SHALL produce the correct product for -2^(WIDTH-1) on either or both operands.
REQ-028 Without the macro, operands and product SHALL be unsigned, and no sign logic SHALL be synthesised.

Verification (WIDTH=4)
REQ-029 Unsigned: m=15, q=15 accepted at edge k -> out_valid at edge k+4, p=225.
REQ-030 Unsigned: m=0, q=9 -> p=0 with the same 4-cycle latency; then m=7, q=1 -> p=7, showing no stale accumulator.
REQ-031 Back-pressure: out_ready=0 for 5 cycles in DONE -> p and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-032 in_valid pulsed with m=3, q=3 during CALC of 5x6 -> p=30, and no extra product is produced.
REQ-033 rst_n pulsed low at CALC cycle 2 -> all outputs reset immediately, no out_valid after release, and a new 2x3 yields p=6.
REQ-034 SIGNED_MULT_EN: -8 x -8 -> p=8'h40; -3 x 5 -> p=8'hF1; -8 x 7 -> p=8'hC8.

Source files
------------

// File: rtl/shift_add_mult.sv
// Iterative shift-and-add multiplier with a valid/ready handshake on both sides.
// Takes one operand pair in IDLE, runs WIDTH add/shift steps in CALC, and holds
// the full 2*WIDTH-bit product in DONE until the consumer takes it.
// Optional feature macro: SIGNED_MULT_EN (two's complement operands and product).
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Latched operand pair (magnitudes in signed mode).
  typedef struct packed {
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
  } opnd_t;

  state_t             state;
  opnd_t              op_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   m_mag;
  logic [WIDTH-1:0]   q_mag;

`ifdef SIGNED_MULT_EN
  logic neg_r;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  assign m_mag = m[WIDTH-1] ? (~m + WIDTH'(1)) : m;
  assign q_mag = q[WIDTH-1] ? (~q + WIDTH'(1)) : q;
  assign res   = neg_r ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;

  // Remember whether the final product must be negated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       neg_r <= 1'b0;
    else if (state == IDLE && in_valid) neg_r <= m[WIDTH-1] ^ q[WIDTH-1];
  end
`else
  assign m_mag = m;
  assign q_mag = q;
  assign res   = acc_nxt;
`endif

  // One partial product per CALC cycle: multiplicand shifted by the bit index.
  always_comb begin
    addend  = '0;
    if (op_r.q[cnt]) addend = {{WIDTH{1'b0}}, op_r.m} << cnt;
    acc_nxt = acc + addend;
  end

  // Control FSM with registered handshake outputs and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= '0;
      cnt       <= '0;
      acc       <= '0;
      p         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= '{m: m_mag, q: q_mag};
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          // Fixed latency: no early exit on zero operands.
          if (cnt == CNT_LAST) begin
            p         <= res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult (WIDTH=4). Stimulus pushes expected
// products; a negedge monitor pops and compares on every output handshake.
module tb_shift_add_mult;
  localparam int W = 4;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic           out_valid;
  logic           out_ready = 1;
  logic [2*W-1:0] p;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];

  shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m(m), .q(q), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted product must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_product: got p=%0h with empty scoreboard", p);
      end else begin
        chk("product", 32'(p), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present an operand pair (called while IDLE, before a rising edge), then
  // scramble m/q and measure latency to out_valid.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] e,
                       input bit push, input bit pulse_in_calc);
    int lat;
    if (push) exp_q.push_back(e);
    m = a; q = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; m = ~a; q = ~b;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (pulse_in_calc && lat == 1) begin
        m = 3; q = 3; in_valid = 1;
      end
      @(posedge clk); #1;
      in_valid = 0;
      lat++;
      if (lat < W) chk("in_ready_calc", 32'(in_ready), 0);
    end
    chk("latency", lat, W);
  endtask

  // Let the monitor take the product and check the return to IDLE.
  task automatic finish_idle();
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
  endtask

  initial begin
    logic [2*W-1:0] e_ff, e_bp, last_p;
`ifdef SIGNED_MULT_EN
    e_ff = 8'h01;  // -1 * -1
    e_bp = 8'h0F;  // -3 * -5
`else
    e_ff = 8'd225;
    e_bp = 8'd143;
`endif
    // Reset state
    #12;
    chk("rst_p", 32'(p), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Release just before an edge region; accept on first edge after release
    @(negedge clk); rst_n = 1;
    issue(4'd15, 4'd15, e_ff, 1, 0);
    finish_idle();

    issue(4'd0, 4'd9, 8'd0, 1, 0);
    finish_idle();
    issue(4'd7, 4'd1, 8'd7, 1, 0);
    finish_idle();

    // Back-pressure in DONE
    out_ready = 0;
    issue(4'd13, 4'd11, e_bp, 1, 0);
    last_p = p;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_p_hold", 32'(p), 32'(last_p));
    end
    out_ready = 1;
    finish_idle();
    chk("p_retained_idle", 32'(p), 32'(last_p));

    // in_valid pulse during CALC must be ignored
    issue(4'd5, 4'd6, 8'd30, 1, 1);
    finish_idle();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) chk("no_extra_product", 32'(out_valid), 0);
    end

    // Reset during CALC cycle 2 discards the operation
    m = 4'd9; q = 4'd9; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0; #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_p", 32'(p), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) chk("post_rst_no_valid", 32'(out_valid), 0);
    end
    chk("post_rst_in_ready", 32'(in_ready), 1);
    issue(4'd2, 4'd3, 8'd6, 1, 0);
    finish_idle();

`ifdef SIGNED_MULT_EN
    issue(4'h8, 4'h8, 8'h40, 1, 0); finish_idle();
    issue(4'hD, 4'h5, 8'hF1, 1, 0); finish_idle();
    issue(4'h8, 4'h7, 8'hC8, 1, 0); finish_idle();
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
